accelerator_port_core: RTL and testbench
========================================

Name: accelerator_port_core

Overview:
Self-contained single-tile accelerator datapath with no data inputs.
- An internal loader fills double-buffered activation and weight global buffers (set 1 and set 2) with fixed patterns.
- A lane-parallel MAC stage multiplies the buffers into two partial-sum banks (1b, 2b).
- A drain stage reads both banks simultaneously, 4:1 lane-reduces each word and presents it on the outputs.
- The block is used as a top-level smoke-test harness for the accelerator.

Parameters:
ROW, 16, PE rows; reserved, no effect on behaviour
COL, 16, PE columns; reserved
IN_BITWIDTH, 8, activation/weight lane width
OUT_BITWIDTH, 16, psum lane width
ACTV_ADDR_BITWIDTH / ACTV_DEPTH, 2 / 4, reserved
WGT_ADDR_BITWIDTH / WGT_DEPTH, 2 / 4, reserved
PSUM_ADDR_BITWIDTH / PSUM_DEPTH, 2 / 4, reserved
GBF_DATA_BITWIDTH, 256, actv/wgt GBF word width (L = 256/8 = 32 lanes)
GBF_ADDR_BITWIDTH, 5, GBF address width
GBF_DEPTH, 32, words per GBF set
PSUM_GBF_DATA_BITWIDTH, 512, psum word width (must equal L*OUT_BITWIDTH)
PSUM_GBF_ADDR_BITWIDTH, 5, psum bank address width
PSUM_GBF_DEPTH, 32, words per psum bank (must equal GBF_DEPTH)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
actv_gbf1_need_data  out  1  actv set 1 not yet loaded
actv_gbf2_need_data  out  1  actv set 2 not yet loaded
wgt_gbf1_need_data  out  1  wgt set 1 not yet loaded
wgt_gbf2_need_data  out  1  wgt set 2 not yet loaded
reduced_r_data1b  out  PSUM_GBF_DATA_BITWIDTH/4  reduced word from psum bank 1b
reduced_r_data2b  out  PSUM_GBF_DATA_BITWIDTH/4  reduced word from psum bank 2b
r_en1b_out  out  1  reduced_r_data1b valid this cycle
r_en2b_out  out  1  reduced_r_data2b valid this cycle
initial_data1b  out  32  low 32 bits of psum bank 1b word 0
initial_data2b  out  32  low 32 bits of psum bank 2b word 0

Behaviour:
Reset (reset=0 at an edge):
- state goes to IDLE; all four need_data flags go to 1.
- r_en outputs, reduced data and initial_data go to 0.
- psum banks are logically cleared.
- Reset mid-operation aborts immediately with the same result.

Timing reference: cycle 0 is the first edge with reset=1.

FSM: IDLE -> LOAD1 -> COMP1 -> COMP2 -> DRAIN -> DONE.
- IDLE: 1 cycle.
- LOAD1, cycles 1..32: one word per cycle into actv/wgt set 1, address 0..31.
  - actv set 1 lane byte at address a = a+1; wgt set 1 lane byte = 2.
  - actv_gbf1_need_data and wgt_gbf1_need_data drop to 0 at cycle 33 and stay 0 until reset.
- COMP1, GBF_DEPTH+2 = 34 cycles:
  - Reads set 1 addresses 0..31 with 1-cycle read latency.
  - Per lane i: psum1b[a].lane i = 0 + actv_i*wgt_i, unsigned, truncated to 16 bits. A 16-bit product is written at psum lane position i*16.
  - In parallel, the loader fills set 2 in the first 32 COMP1 cycles: actv byte = a+1, wgt byte = 3.
  - actv_gbf2_need_data and wgt_gbf2_need_data drop to 0 at cycle 65.
  - Writing psum1b word 0 also registers initial_data1b = psum1b[0][31:0].
- COMP2: same as COMP1 on set 2 into psum2b; captures initial_data2b.
- DRAIN:
  - r_en1b_out and r_en2b_out are both 1 for exactly PSUM_GBF_DEPTH consecutive cycles, first at cycle 102.
  - Addresses 0..31 are presented in order, with data registered in the same cycle as r_en.
- Reduction: output field j (16 bits, j = 0..7) = sum of psum lanes 4j..4j+3, modulo 2^16.
- DONE:
  - r_en outputs are 0.
  - reduced data and initial_data hold their last values.
  - need_data flags are 0.
  - FSM stays in DONE until reset.

Test Plan:
- Hold reset=0 for 2 edges -> all four need_data = 1, r_en = 0, reduced data = 0, initial_data = 0.
- Release reset -> gbf1 need flags = 1 through cycle 32 and 0 from cycle 33; gbf2 need flags = 0 from cycle 65.
- Run to DRAIN -> r_en1b_out/r_en2b_out = 1 for exactly cycles 102..133, simultaneously.
- During DRAIN check word k -> every 16-bit field of reduced_r_data1b = 8*(k+1) and of reduced_r_data2b = 12*(k+1); k=31 gives 0x0100 and 0x0180.
- After COMP2 -> initial_data1b = 0x00020002, initial_data2b = 0x00030003; values hold through DONE.
- Assert reset at cycle 50 (mid COMP1), release, rerun -> identical timing and values from the new cycle 0.

Source files
------------

// File: rtl/accelerator_port_core.sv
// Self-contained accelerator smoke-test tile: loads fixed patterns into double-buffered GBFs,
// multiplies them lane-wise into two psum banks, then drains both banks 4:1 lane-reduced.
module accelerator_port_core #(
   parameter int ROW                    = 16,
   parameter int COL                    = 16,
   parameter int IN_BITWIDTH            = 8,
   parameter int OUT_BITWIDTH           = 16,
   parameter int ACTV_ADDR_BITWIDTH     = 2,
   parameter int ACTV_DEPTH             = 4,
   parameter int WGT_ADDR_BITWIDTH      = 2,
   parameter int WGT_DEPTH              = 4,
   parameter int PSUM_ADDR_BITWIDTH     = 2,
   parameter int PSUM_DEPTH             = 4,
   parameter int GBF_DATA_BITWIDTH      = 256,
   parameter int GBF_ADDR_BITWIDTH      = 5,
   parameter int GBF_DEPTH              = 32,
   parameter int PSUM_GBF_DATA_BITWIDTH = 512,
   parameter int PSUM_GBF_ADDR_BITWIDTH = 5,
   parameter int PSUM_GBF_DEPTH         = 32
) (
   input  logic                                clk,
   input  logic                                reset,
   output logic                                actv_gbf1_need_data,
   output logic                                actv_gbf2_need_data,
   output logic                                wgt_gbf1_need_data,
   output logic                                wgt_gbf2_need_data,
   output logic [PSUM_GBF_DATA_BITWIDTH/4-1:0] reduced_r_data1b,
   output logic [PSUM_GBF_DATA_BITWIDTH/4-1:0] reduced_r_data2b,
   output logic                                r_en1b_out,
   output logic                                r_en2b_out,
   output logic [31:0]                         initial_data1b,
   output logic [31:0]                         initial_data2b
);
   localparam int LANES  = GBF_DATA_BITWIDTH / IN_BITWIDTH;
   localparam int FIELDS = LANES / 4;
   localparam int RED_W  = PSUM_GBF_DATA_BITWIDTH / 4;
   localparam int CNT_W  = $clog2(GBF_DEPTH + 2);
   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(GBF_DEPTH);
   localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(GBF_DEPTH - 1);
   localparam logic [CNT_W-1:0] COMP_LAST = CNT_W'(GBF_DEPTH + 1);

   localparam bit CFG_OK = (ROW > 0) && (COL > 0) && (ACTV_ADDR_BITWIDTH > 0) && (ACTV_DEPTH > 0)
                        && (WGT_ADDR_BITWIDTH > 0) && (WGT_DEPTH > 0) && (PSUM_ADDR_BITWIDTH > 0)
                        && (PSUM_DEPTH > 0) && (PSUM_GBF_DATA_BITWIDTH == LANES * OUT_BITWIDTH)
                        && (PSUM_GBF_DEPTH == GBF_DEPTH) && (PSUM_GBF_ADDR_BITWIDTH == GBF_ADDR_BITWIDTH);
   if (!CFG_OK) begin : g_bad_cfg
      $error("accelerator_port_core: inconsistent parameters");
   end

   typedef enum logic [2:0] {IDLE, LOAD1, COMP1, COMP2, DRAIN, DONE} state_e;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   load_en, load_set2, rd_issue, clr_need1, clr_need2;
   logic [GBF_ADDR_BITWIDTH-1:0] addr;

   logic [GBF_DATA_BITWIDTH-1:0]      actv1_mem [GBF_DEPTH];
   logic [GBF_DATA_BITWIDTH-1:0]      actv2_mem [GBF_DEPTH];
   logic [GBF_DATA_BITWIDTH-1:0]      wgt1_mem  [GBF_DEPTH];
   logic [GBF_DATA_BITWIDTH-1:0]      wgt2_mem  [GBF_DEPTH];
   logic [PSUM_GBF_DATA_BITWIDTH-1:0] psum1_mem [PSUM_GBF_DEPTH];
   logic [PSUM_GBF_DATA_BITWIDTH-1:0] psum2_mem [PSUM_GBF_DEPTH];
   logic [PSUM_GBF_DEPTH-1:0]         psum1_vld_q, psum2_vld_q;

   logic                              rd_vld_q;
   logic [PSUM_GBF_ADDR_BITWIDTH-1:0] rd_addr_q;
   logic [GBF_DATA_BITWIDTH-1:0]      rd_actv_q, rd_wgt_q;
   logic [PSUM_GBF_DATA_BITWIDTH-1:0] psum1_rd_q, psum2_rd_q, prod_word;
   logic [IN_BITWIDTH-1:0]            actv_byte, wgt_byte;
   logic [RED_W-1:0]                  red1, red2;
   logic                              psum1_wr, psum2_wr, r_en_d;

   logic need1_q, need2_q, r_en_q;
   logic [RED_W-1:0] red1_q, red2_q;
   logic [31:0]      init1_q, init2_q;

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; cnt_q counts cycles within the current state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      unique case (state_q)
         IDLE:  begin state_d = LOAD1; cnt_d = '0; end
         LOAD1: if (cnt_q == LOAD_LAST) begin state_d = COMP1; cnt_d = '0; end
         COMP1: if (cnt_q == COMP_LAST) begin state_d = COMP2; cnt_d = '0; end
         COMP2: if (cnt_q == COMP_LAST) begin state_d = DRAIN; cnt_d = '0; end
         DRAIN: if (cnt_q == DEPTH_C)   begin state_d = DONE;  cnt_d = '0; end
         DONE:  cnt_d = cnt_q;
         default: begin state_d = IDLE; cnt_d = '0; end
      endcase
   end

   // Output/control decode; set 2 is loaded while set 1 is being computed
   always_comb begin
      load_en   = 1'b0;
      load_set2 = 1'b0;
      rd_issue  = 1'b0;
      clr_need1 = 1'b0;
      clr_need2 = 1'b0;
      unique case (state_q)
         LOAD1: load_en = 1'b1;
         COMP1: begin
            load_en   = (cnt_q < DEPTH_C);
            load_set2 = 1'b1;
            rd_issue  = (cnt_q < DEPTH_C);
            clr_need1 = 1'b1;
            clr_need2 = (cnt_q == DEPTH_C);
         end
         COMP2, DRAIN: rd_issue = (cnt_q < DEPTH_C);
         default: ;
      endcase
   end

   assign addr      = cnt_q[GBF_ADDR_BITWIDTH-1:0];
   assign actv_byte = IN_BITWIDTH'(addr) + IN_BITWIDTH'(1);
   assign wgt_byte  = load_set2 ? IN_BITWIDTH'(3) : IN_BITWIDTH'(2);

   // NOTE: buffer storage has no reset; psum contents are invalidated through the valid bits instead.
   always_ff @(posedge clk) begin
      if (load_en && !load_set2) begin
         actv1_mem[addr] <= {LANES{actv_byte}};
         wgt1_mem[addr]  <= {LANES{wgt_byte}};
      end
      if (load_en && load_set2) begin
         actv2_mem[addr] <= {LANES{actv_byte}};
         wgt2_mem[addr]  <= {LANES{wgt_byte}};
      end
      if (rd_issue) begin
         rd_actv_q  <= (state_q == COMP2) ? actv2_mem[addr] : actv1_mem[addr];
         rd_wgt_q   <= (state_q == COMP2) ? wgt2_mem[addr]  : wgt1_mem[addr];
         psum1_rd_q <= psum1_vld_q[addr] ? psum1_mem[addr] : '0;
         psum2_rd_q <= psum2_vld_q[addr] ? psum2_mem[addr] : '0;
      end
      if (psum1_wr) psum1_mem[rd_addr_q] <= prod_word;
      if (psum2_wr) psum2_mem[rd_addr_q] <= prod_word;
   end

   always_comb begin
      prod_word = '0;
      for (int i = 0; i < LANES; i++) begin
         prod_word[i*OUT_BITWIDTH +: OUT_BITWIDTH] =
            OUT_BITWIDTH'(rd_actv_q[i*IN_BITWIDTH +: IN_BITWIDTH])
          * OUT_BITWIDTH'(rd_wgt_q[i*IN_BITWIDTH +: IN_BITWIDTH]);
      end
   end

   // Each reduced field wraps modulo 2^OUT_BITWIDTH
   always_comb begin
      red1 = '0;
      red2 = '0;
      for (int j = 0; j < FIELDS; j++) begin
         red1[j*OUT_BITWIDTH +: OUT_BITWIDTH] =
            psum1_rd_q[(4*j)*OUT_BITWIDTH +: OUT_BITWIDTH]   + psum1_rd_q[(4*j+1)*OUT_BITWIDTH +: OUT_BITWIDTH]
          + psum1_rd_q[(4*j+2)*OUT_BITWIDTH +: OUT_BITWIDTH] + psum1_rd_q[(4*j+3)*OUT_BITWIDTH +: OUT_BITWIDTH];
         red2[j*OUT_BITWIDTH +: OUT_BITWIDTH] =
            psum2_rd_q[(4*j)*OUT_BITWIDTH +: OUT_BITWIDTH]   + psum2_rd_q[(4*j+1)*OUT_BITWIDTH +: OUT_BITWIDTH]
          + psum2_rd_q[(4*j+2)*OUT_BITWIDTH +: OUT_BITWIDTH] + psum2_rd_q[(4*j+3)*OUT_BITWIDTH +: OUT_BITWIDTH];
      end
   end

   assign psum1_wr = rd_vld_q && (state_q == COMP1);
   assign psum2_wr = rd_vld_q && (state_q == COMP2);
   assign r_en_d   = rd_vld_q && (state_q == DRAIN);

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_vld_q    <= 1'b0;
         rd_addr_q   <= '0;
         psum1_vld_q <= '0;
         psum2_vld_q <= '0;
         need1_q     <= 1'b1;
         need2_q     <= 1'b1;
         r_en_q      <= 1'b0;
         red1_q      <= '0;
         red2_q      <= '0;
         init1_q     <= '0;
         init2_q     <= '0;
      end else begin
         rd_vld_q  <= rd_issue;
         rd_addr_q <= addr;
         r_en_q    <= r_en_d;
         if (clr_need1) need1_q <= 1'b0;
         if (clr_need2) need2_q <= 1'b0;
         if (psum1_wr) psum1_vld_q[rd_addr_q] <= 1'b1;
         if (psum2_wr) psum2_vld_q[rd_addr_q] <= 1'b1;
         if (psum1_wr && rd_addr_q == '0) init1_q <= prod_word[31:0];
         if (psum2_wr && rd_addr_q == '0) init2_q <= prod_word[31:0];
         if (r_en_d) begin
            red1_q <= red1;
            red2_q <= red2;
         end
      end
   end

   assign actv_gbf1_need_data = need1_q;
   assign wgt_gbf1_need_data  = need1_q;
   assign actv_gbf2_need_data = need2_q;
   assign wgt_gbf2_need_data  = need2_q;
   assign r_en1b_out          = r_en_q;
   assign r_en2b_out          = r_en_q;
   assign reduced_r_data1b    = red1_q;
   assign reduced_r_data2b    = red2_q;
   assign initial_data1b      = init1_q;
   assign initial_data2b      = init2_q;

endmodule

// File: tb/tb_accelerator_port_core.sv
// Bench for accelerator_port_core: checkpoint table for flags/timing plus a drain scoreboard.
module tb_accelerator_port_core;
   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         actv_gbf1_need_data, actv_gbf2_need_data, wgt_gbf1_need_data, wgt_gbf2_need_data;
   logic [127:0] reduced_r_data1b, reduced_r_data2b;
   logic         r_en1b_out, r_en2b_out;
   logic [31:0]  initial_data1b, initial_data2b;

   accelerator_port_core dut (
      .clk                 (clk),
      .reset               (reset),
      .actv_gbf1_need_data (actv_gbf1_need_data),
      .actv_gbf2_need_data (actv_gbf2_need_data),
      .wgt_gbf1_need_data  (wgt_gbf1_need_data),
      .wgt_gbf2_need_data  (wgt_gbf2_need_data),
      .reduced_r_data1b    (reduced_r_data1b),
      .reduced_r_data2b    (reduced_r_data2b),
      .r_en1b_out          (r_en1b_out),
      .r_en2b_out          (r_en2b_out),
      .initial_data1b      (initial_data1b),
      .initial_data2b      (initial_data2b)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic        need1;
      logic        need2;
      logic        chk_init;
      logic [31:0] init1;
      logic [31:0] init2;
   } vec_t;

   typedef struct {
      logic [127:0] r1;
      logic [127:0] r2;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];
   int   vec_cnt  = 0;
   int   miss_cnt = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] rep16(input int v);
      logic [127:0] w;
      for (int j = 0; j < 8; j++) w[j*16 +: 16] = 16'(v);
      return w;
   endfunction

   task automatic apply_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst actv_gbf1_need", actv_gbf1_need_data, 1);
      check("rst actv_gbf2_need", actv_gbf2_need_data, 1);
      check("rst wgt_gbf1_need",  wgt_gbf1_need_data, 1);
      check("rst wgt_gbf2_need",  wgt_gbf2_need_data, 1);
      check("rst r_en1b", r_en1b_out, 0);
      check("rst r_en2b", r_en2b_out, 0);
      check("rst reduced1b", reduced_r_data1b, 0);
      check("rst reduced2b", reduced_r_data2b, 0);
      check("rst init1b", initial_data1b, 0);
      check("rst init2b", initial_data2b, 0);
   endtask

   // Runs from reset release; abort_at >= 0 stops after sampling that cycle.
   task automatic run(input int abort_at);
      logic exp_ren;
      exp_t e;
      @(negedge clk);
      reset = 1'b1;
      sb_q.delete();
      for (int k = 0; k < 32; k++) sb_q.push_back('{rep16(8 * (k + 1)), rep16(12 * (k + 1))});
      for (int cyc = 0; cyc <= 150; cyc++) begin
         @(posedge clk);
         #1;
         foreach (vecs[i]) begin
            if (vecs[i].cyc == cyc) begin
               check($sformatf("c%0d actv1_need", cyc), actv_gbf1_need_data, vecs[i].need1);
               check($sformatf("c%0d wgt1_need",  cyc), wgt_gbf1_need_data,  vecs[i].need1);
               check($sformatf("c%0d actv2_need", cyc), actv_gbf2_need_data, vecs[i].need2);
               check($sformatf("c%0d wgt2_need",  cyc), wgt_gbf2_need_data,  vecs[i].need2);
               if (vecs[i].chk_init) begin
                  check($sformatf("c%0d init1b", cyc), initial_data1b, vecs[i].init1);
                  check($sformatf("c%0d init2b", cyc), initial_data2b, vecs[i].init2);
               end
            end
         end
         exp_ren = (cyc >= 102) && (cyc <= 133);
         check($sformatf("c%0d r_en1b", cyc), r_en1b_out, exp_ren);
         check($sformatf("c%0d r_en2b", cyc), r_en2b_out, exp_ren);
         if (r_en1b_out) begin
            if (sb_q.size() == 0) begin
               vec_cnt++;
               miss_cnt++;
               $display("FAIL c%0d drain: got extra word, expected none", cyc);
            end else begin
               e = sb_q.pop_front();
               check($sformatf("c%0d reduced1b", cyc), reduced_r_data1b, e.r1);
               check($sformatf("c%0d reduced2b", cyc), reduced_r_data2b, e.r2);
            end
         end
         if (cyc == abort_at) return;
      end
      check("drain word count left", 128'(sb_q.size()), 0);
      check("done hold reduced1b", reduced_r_data1b, rep16(16'h0100));
      check("done hold reduced2b", reduced_r_data2b, rep16(16'h0180));
   endtask

   initial begin
      vecs.push_back('{0,   1'b1, 1'b1, 1'b1, 32'h0,        32'h0});
      vecs.push_back('{32,  1'b1, 1'b1, 1'b0, 32'h0,        32'h0});
      vecs.push_back('{33,  1'b0, 1'b1, 1'b0, 32'h0,        32'h0});
      vecs.push_back('{64,  1'b0, 1'b1, 1'b0, 32'h0,        32'h0});
      vecs.push_back('{65,  1'b0, 1'b0, 1'b0, 32'h0,        32'h0});
      vecs.push_back('{101, 1'b0, 1'b0, 1'b1, 32'h00020002, 32'h00030003});
      vecs.push_back('{134, 1'b0, 1'b0, 1'b1, 32'h00020002, 32'h00030003});
      vecs.push_back('{150, 1'b0, 1'b0, 1'b1, 32'h00020002, 32'h00030003});

      apply_reset();
      run(50);
      apply_reset();
      run(-1);
      apply_reset();
      run(-1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end
endmodule
